mm_line_requester: RTL and testbench
====================================

Name: mm_line_requester

Overview:
- Initiator for the main-memory line/bypass port; sits between the L1 cache controller and main memory.
- Accepts one cache-side request at a time: line fill, line writeback, writeback-then-fill (dirty eviction), or bypass word read/write.
- Sequences the memory port signals, collects the memory return, enforces address-range and timeout checks, and returns one response per request.

Parameters:
- IDX_MSB, 14, highest legal address bit. Bits [31:IDX_MSB+1] must be zero.
- TIMEOUT, 16, maximum cycles to wait for mm_valid after a read issue (must be ≥2).

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  3  operation: 0 FILL, 1 WB, 2 WB_FILL, 3 BYP_RD, 4 BYP_WR; 5-7 illegal
- req_addr  in  32  fill, bypass or WB target address
- req_wb_addr  in  32  eviction address, WB_FILL only
- req_be  in  4  bypass write byte enables
- req_wd  in  256  writeback line; bypass write data in [31:0]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  256  fill line; bypass read word in [31:0] with upper bits zero
- rsp_err  out  1  qualifies rsp_valid: range, illegal-op or timeout error
- mm_a  out  32  memory address
- mm_be  out  4  memory byte enables (bypass write only)
- mm_write  out  1  memory write strobe
- mm_read  out  1  memory read strobe
- mm_wd  out  256  memory write data
- mm_bypass  out  1  word/byte access select
- mm_rd  in  256  memory read data
- mm_valid  in  1  read data valid, one cycle after mm_read

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - req_ready=1 after reset release.
  - All mm_* outputs are 0; rsp_valid=0, rsp_err=0, rsp_data=0.
  - The timeout counter is 0.
  - Reset mid-operation abandons the operation and produces no response.
  - A late mm_valid after reset is ignored.
- States: IDLE, WB_ISSUE, RD_ISSUE, RD_WAIT, RESP.
- Accept:
  - A request is accepted when req_valid&req_ready at posedge (cycle T).
  - All request fields are registered at acceptance.
  - req_ready deasserts from T+1 until the block returns to IDLE.
- Line address alignment: line ops force mm_a[4:0]=0. Bypass ops force mm_a[1:0]=0.
- Range check at accept:
  - Any nonzero bit above IDX_MSB in a used address, or an illegal op, sends the FSM straight to RESP with err=1.
  - No mm_* strobe is issued.
  - rsp_valid fires at T+1.
- FILL: RD_ISSUE at T+1 (mm_read=1, mm_bypass=0) -> RD_WAIT -> capture mm_rd on mm_valid -> RESP. Nominal rsp_valid is at T+3.
- WB: WB_ISSUE at T+1 (mm_write=1, mm_wd=line, mm_bypass=0) -> RESP. rsp_valid is at T+2 with rsp_data=0.
- WB_FILL:
  - WB_ISSUE at T+1 uses req_wb_addr; RD_ISSUE at T+2 uses req_addr.
  - rsp_valid is at T+4.
  - A range error on either address aborts before any strobe.
- BYP_RD:
  - Same sequence as FILL with mm_bypass=1.
  - rsp_data={224'b0, mm_rd[31:0]}.
- BYP_WR:
  - Same sequence as WB with mm_bypass=1, mm_be=req_be, mm_wd[31:0]=data, upper bits 0.
  - be==0 still issues the write cycle; it is a harmless no-op.
- Strobes: every mm_* strobe lasts exactly one cycle. mm_read and mm_write are never high together. mm_a, mm_wd and mm_be are 0 when no strobe is high.
- Timeout:
  - The counter starts at 1 in RD_WAIT and increments each cycle without mm_valid.
  - Reaching TIMEOUT goes to RESP with err=1 and rsp_data=0.
  - mm_valid arriving in the same cycle that the count reaches TIMEOUT wins: success.
- Spurious mm_valid outside RD_WAIT is ignored and leaves state unchanged.
- RESP:
  - rsp_valid=1 for one cycle; rsp_data and rsp_err are valid only then and hold until the next RESP.
  - Next state is IDLE; req_ready=1 in the following cycle.
  - There is no back-to-back accept in the RESP cycle.

Decomposition:
- Shared package mm_req_pkg holds:
  - op encodings (OP_FILL..OP_BYP_WR)
  - FSM state encoding
  - LINE_W=256, WORD_W=32
  - address-field constants: line offset [4:0], word select [4:2]
- One sub-module, mm_timeout_ctr:
  - inputs: clear, enable
  - output: expired at TIMEOUT
  - parameter: TIMEOUT

Test Plan:
- FILL addr 0x0000_0040, memory returns line L one cycle after mm_read -> mm_read at T+1 with mm_a=0x40; rsp_valid at T+3, rsp_data=L, err=0.
- WB_FILL wb_addr 0x20, addr 0x60, wd=W -> mm_write at T+1 (a=0x20, wd=W), mm_read at T+2 (a=0x60); rsp_valid at T+4; memory line at 0x20 reads back W.
- BYP_WR addr 0x44, be=4'b0010, wd[31:0]=0xAABBCCDD -> mm_bypass=1, mm_be=0010 at T+1; a following BYP_RD of 0x44 returns byte1=0xCC with other bytes unchanged.
- FILL addr 0x0001_0000 (bit16 set, IDX_MSB=14) -> no mm_* strobe; rsp_valid at T+1, rsp_err=1.
- BYP_RD with mm_valid held low -> rsp_err=1 after TIMEOUT cycles in RD_WAIT; a repeat with mm_valid on the final count cycle -> err=0.
- reset=0 during RD_WAIT, then mm_valid pulses -> no rsp_valid; req_ready=1 after reset release.

Source files
------------

// File: rtl/mm_line_requester_pkg.sv
// rtl/mm_line_requester_pkg.sv - shared encodings and address helpers for the main-memory line requester
package mm_req_pkg;

    localparam int LINE_W       = 256;
    localparam int WORD_W       = 32;
    // Line offset is [LINE_OFF_MSB:0]; word select is [LINE_OFF_MSB:WORD_SEL_LSB].
    localparam int LINE_OFF_MSB = 4;
    localparam int WORD_SEL_LSB = 2;

    typedef enum logic [2:0] {
        OP_FILL    = 3'd0,
        OP_WB      = 3'd1,
        OP_WB_FILL = 3'd2,
        OP_BYP_RD  = 3'd3,
        OP_BYP_WR  = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_ISSUE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

    // Line ops address whole lines; bypass ops address words.
    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic bypass);
        logic [31:0] r;
        r = a;
        if (bypass) begin
            r[WORD_SEL_LSB-1:0] = '0;
        end else begin
            r[LINE_OFF_MSB:0] = '0;
        end
        return r;
    endfunction

    function automatic logic is_bypass(input logic [2:0] op);
        return (op == OP_BYP_RD) || (op == OP_BYP_WR);
    endfunction

    function automatic logic is_read_only(input logic [2:0] op);
        return (op == OP_FILL) || (op == OP_BYP_RD);
    endfunction

endpackage

// File: rtl/mm_line_requester_if.sv
// rtl/mm_line_requester_if.sv - main-memory line/bypass port bundle
interface mm_line_requester_if;
    import mm_req_pkg::*;

    logic [31:0]       mm_a;
    logic [3:0]        mm_be;
    logic              mm_write;
    logic              mm_read;
    logic [LINE_W-1:0] mm_wd;
    logic              mm_bypass;
    logic [LINE_W-1:0] mm_rd;
    logic              mm_valid;

    modport master (
        output mm_a, mm_be, mm_write, mm_read, mm_wd, mm_bypass,
        input  mm_rd, mm_valid
    );

    modport slave (
        input  mm_a, mm_be, mm_write, mm_read, mm_wd, mm_bypass,
        output mm_rd, mm_valid
    );
endinterface

// File: rtl/mm_line_requester_timeout_ctr.sv
// rtl/mm_line_requester_timeout_ctr.sv - read-wait cycle counter with expiry flag
module mm_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // clear loads 1 so the first wait cycle already counts; saturate at expiry
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(1);
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT));
endmodule

// File: rtl/mm_line_requester.sv
// rtl/mm_line_requester.sv - single-outstanding initiator for the main-memory line/bypass port
module mm_line_requester
    import mm_req_pkg::*;
#(
    parameter int IDX_MSB = 14,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wb_addr,
    input  logic [3:0]        req_be,
    input  logic [LINE_W-1:0] req_wd,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_data,
    output logic              rsp_err,
    mm_line_requester_if.master mm
);

    state_e            state, state_n;
    logic [2:0]        op_q;
    logic [31:0]       addr_q;
    logic [31:0]       wb_addr_q;
    logic [3:0]        be_q;
    logic [LINE_W-1:0] wd_q;
    logic              byp_q;

    logic              load_req;
    logic              rsp_load;
    logic              rsp_err_n;
    logic [LINE_W-1:0] rsp_data_n;
    logic              ctr_clear;
    logic              ctr_en;
    logic              expired;
    logic              req_bad;

    logic [31:0]       a_o;
    logic [3:0]        be_o;
    logic              write_o;
    logic              read_o;
    logic [LINE_W-1:0] wd_o;
    logic              bypass_o;

    // Any used address reaching above IDX_MSB, or an unknown op, is refused before any strobe.
    assign req_bad = (req_op > OP_BYP_WR)
                   || (|req_addr[31:IDX_MSB+1])
                   || ((req_op == OP_WB_FILL) && (|req_wb_addr[31:IDX_MSB+1]));

    mm_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (expired)
    );

    // state register, captured request fields and held response
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wb_addr_q <= '0;
            be_q      <= '0;
            wd_q      <= '0;
            byp_q     <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state <= state_n;
            if (load_req) begin
                op_q      <= req_op;
                addr_q    <= req_addr;
                wb_addr_q <= req_wb_addr;
                be_q      <= req_be;
                wd_q      <= req_wd;
                byp_q     <= is_bypass(req_op);
            end
            if (rsp_load) begin
                rsp_err  <= rsp_err_n;
                rsp_data <= rsp_data_n;
            end
        end
    end

    // next state, response capture and timeout control
    always_comb begin
        state_n    = state;
        load_req   = 1'b0;
        rsp_load   = 1'b0;
        rsp_err_n  = 1'b0;
        rsp_data_n = '0;
        ctr_clear  = 1'b0;
        ctr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    load_req = 1'b1;
                    if (req_bad) begin
                        state_n   = ST_RESP;
                        rsp_load  = 1'b1;
                        rsp_err_n = 1'b1;
                    end else if (is_read_only(req_op)) begin
                        state_n = ST_RD_ISSUE;
                    end else begin
                        state_n = ST_WB_ISSUE;
                    end
                end
            end
            ST_WB_ISSUE: begin
                if (op_q == OP_WB_FILL) begin
                    state_n = ST_RD_ISSUE;
                end else begin
                    state_n  = ST_RESP;
                    rsp_load = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                ctr_clear = 1'b1;
                state_n   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // data in the final count cycle still counts as success
                if (mm.mm_valid) begin
                    state_n  = ST_RESP;
                    rsp_load = 1'b1;
                    if (byp_q) begin
                        rsp_data_n = {{(LINE_W-WORD_W){1'b0}}, mm.mm_rd[WORD_W-1:0]};
                    end else begin
                        rsp_data_n = mm.mm_rd;
                    end
                end else if (expired) begin
                    state_n   = ST_RESP;
                    rsp_load  = 1'b1;
                    rsp_err_n = 1'b1;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // memory port drive: everything is zero outside the single strobe cycle
    always_comb begin
        a_o      = '0;
        be_o     = '0;
        write_o  = 1'b0;
        read_o   = 1'b0;
        wd_o     = '0;
        bypass_o = 1'b0;
        case (state)
            ST_WB_ISSUE: begin
                write_o  = 1'b1;
                bypass_o = byp_q;
                a_o      = align_addr((op_q == OP_WB_FILL) ? wb_addr_q : addr_q, byp_q);
                if (byp_q) begin
                    be_o = be_q;
                    wd_o = {{(LINE_W-WORD_W){1'b0}}, wd_q[WORD_W-1:0]};
                end else begin
                    wd_o = wd_q;
                end
            end
            ST_RD_ISSUE: begin
                read_o   = 1'b1;
                bypass_o = byp_q;
                a_o      = align_addr(addr_q, byp_q);
            end
            default: begin
            end
        endcase
    end

    assign mm.mm_a      = a_o;
    assign mm.mm_be     = be_o;
    assign mm.mm_write  = write_o;
    assign mm.mm_read   = read_o;
    assign mm.mm_wd     = wd_o;
    assign mm.mm_bypass = bypass_o;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_mm_line_requester.sv
// tb/tb_mm_line_requester.sv - randomized self-checking bench for mm_line_requester
module tb_mm_line_requester;
    import mm_req_pkg::*;

    localparam int TO  = 16;
    localparam int IDX = 14;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_op = '0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_wb_addr = '0;
    logic [3:0]   req_be = '0;
    logic [255:0] req_wd = '0;
    logic         rsp_valid;
    logic [255:0] rsp_data;
    logic         rsp_err;

    always #5 clk = ~clk;

    mm_line_requester_if mm_if ();

    mm_line_requester #(
        .IDX_MSB (IDX),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wb_addr (req_wb_addr),
        .req_be      (req_be),
        .req_wd      (req_wd),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .mm          (mm_if.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- memories: environment (driven by strobes) and reference (driven by request semantics)
    logic [255:0] env_mem [int unsigned];
    logic [255:0] ref_mem [int unsigned];

    function automatic logic [255:0] init_line(input int unsigned idx);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = idx * 32'h9E37_79B1 + k * 32'h0101_0101 + 32'h5A5A_0001;
        return r;
    endfunction

    function automatic logic [255:0] env_get(input int unsigned i);
        return env_mem.exists(i) ? env_mem[i] : init_line(i);
    endfunction

    function automatic logic [255:0] ref_get(input int unsigned i);
        return ref_mem.exists(i) ? ref_mem[i] : init_line(i);
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] line, input int w, input logic [3:0] be, input logic [31:0] d);
        logic [255:0] r;
        r = line;
        for (int b = 0; b < 4; b++) if (be[b]) r[w*32 + b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // memory responder: read data appears lat_cfg cycles after the mm_read cycle
    int           lat_cfg = 1;
    int           cnt = 0;
    logic [255:0] pend_data = '0;
    logic [255:0] rd_bus = '0;
    logic         env_valid = 1'b0;
    logic         spur = 1'b0;

    assign mm_if.mm_valid = env_valid | spur;
    assign mm_if.mm_rd    = rd_bus;

    always @(negedge clk) begin
        int unsigned  idx;
        int           w;
        logic [255:0] line;
        env_valid = 1'b0;
        rd_bus    = rand_line();
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                env_valid = 1'b1;
                rd_bus    = pend_data;
            end
        end
        if (mm_if.mm_write) begin
            idx  = int'(mm_if.mm_a >> 5);
            w    = int'(mm_if.mm_a[4:2]);
            line = env_get(idx);
            if (mm_if.mm_bypass) line = merge(line, w, mm_if.mm_be, mm_if.mm_wd[31:0]);
            else                 line = mm_if.mm_wd;
            env_mem[idx] = line;
        end
        if (mm_if.mm_read) begin
            idx       = int'(mm_if.mm_a >> 5);
            w         = int'(mm_if.mm_a[4:2]);
            line      = env_get(idx);
            pend_data = line;
            if (mm_if.mm_bypass) pend_data[31:0] = line[w*32 +: 32];
            cnt = lat_cfg;
        end
    end

    logic [255:0] last_rsp;

    // one request against the reference model: latency, response and strobe contents
    task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wb,
                           input logic [3:0] be, input logic [255:0] wd, input int lat);
        logic         byp, e_err, idle_bad, overlap;
        int           e_lat, e_nw, e_nr, e_rcyc, n_w, n_r, w_cyc, r_cyc, got_lat, wi;
        logic [31:0]  e_wa, e_ra, g_wa, g_ra;
        logic [255:0] e_wd, e_data, g_wd;
        logic [3:0]   e_be, g_be;
        logic         g_wbyp, g_rbyp, g_err;
        byp    = (op == 3) || (op == 4);
        e_err  = (op > 4) || (|addr[31:IDX+1]) || ((op == 2) && (|wb[31:IDX+1]));
        e_nw = 0; e_nr = 0; e_rcyc = 0; e_lat = 1; e_data = '0;
        e_wa = '0; e_ra = '0; e_wd = '0; e_be = '0;
        wi = int'(addr[4:2]);
        if (!e_err) begin
            if (op == 1 || op == 2 || op == 4) begin
                e_nw = 1;
                e_wa = byp ? {addr[31:2], 2'b00} : {(op == 2 ? wb[31:5] : addr[31:5]), 5'b0};
                e_wd = byp ? {224'b0, wd[31:0]} : wd;
                e_be = byp ? be : 4'b0;
                if (byp) ref_mem[int'(addr >> 5)] = merge(ref_get(int'(addr >> 5)), wi, be, wd[31:0]);
                else     ref_mem[int'((op == 2 ? wb : addr) >> 5)] = wd;
                e_lat = 2;
            end
            if (op == 0 || op == 2 || op == 3) begin
                e_nr   = 1;
                e_rcyc = (op == 2) ? 2 : 1;
                e_ra   = byp ? {addr[31:2], 2'b00} : {addr[31:5], 5'b0};
                if (lat <= TO) begin
                    e_lat  = e_rcyc + lat + 1;
                    e_data = ref_get(int'(addr >> 5));
                    if (byp) e_data = {224'b0, e_data[wi*32 +: 32]};
                end else begin
                    e_lat = e_rcyc + TO + 1;
                    e_err = 1'b1;
                end
            end
        end
        lat_cfg = lat;
        @(posedge clk); #1;
        chk("ready_pre", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wb_addr = wb; req_be = be; req_wd = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wb_addr = $urandom; req_wd = rand_line(); req_be = 4'($urandom);
        n_w = 0; n_r = 0; w_cyc = 0; r_cyc = 0; got_lat = 0; idle_bad = 0; overlap = 0;
        g_wa = '0; g_ra = '0; g_wd = '0; g_be = '0; g_wbyp = 0; g_rbyp = 0; g_err = 0;
        for (int n = 1; n <= TO + 10; n++) begin
            if (mm_if.mm_read && mm_if.mm_write) overlap = 1;
            if (!mm_if.mm_read && !mm_if.mm_write &&
                (mm_if.mm_a != 0 || mm_if.mm_wd != 0 || mm_if.mm_be != 0 || mm_if.mm_bypass)) idle_bad = 1;
            if (mm_if.mm_write) begin
                n_w++; w_cyc = n; g_wa = mm_if.mm_a; g_wd = mm_if.mm_wd; g_be = mm_if.mm_be; g_wbyp = mm_if.mm_bypass;
            end
            if (mm_if.mm_read) begin
                n_r++; r_cyc = n; g_ra = mm_if.mm_a; g_rbyp = mm_if.mm_bypass;
            end
            if (rsp_valid) begin
                got_lat = n; g_err = rsp_err; last_rsp = rsp_data;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rsp_lat", got_lat, e_lat);
        chk("rsp_err", g_err, e_err);
        chk("rsp_data", last_rsp, e_data);
        chk("n_write", n_w, e_nw);
        chk("n_read", n_r, e_nr);
        chk("overlap", overlap, 0);
        chk("idle_zero", idle_bad, 0);
        if (e_nw == 1 && n_w == 1) begin
            chk("wr_cyc", w_cyc, 1);
            chk("wr_a", g_wa, e_wa);
            chk("wr_wd", g_wd, e_wd);
            chk("wr_be", g_be, e_be);
            chk("wr_byp", g_wbyp, byp);
        end
        if (e_nr == 1 && n_r == 1) begin
            chk("rd_cyc", r_cyc, e_rcyc);
            chk("rd_a", g_ra, e_ra);
            chk("rd_byp", g_rbyp, byp);
        end
        @(posedge clk); #1;
        chk("rsp_drop", rsp_valid, 0);
        chk("ready_post", req_ready, 1);
        chk("rsp_hold", rsp_data, last_rsp);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, wb;
        int          pick, lat, seen;

        // reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mm_read", mm_if.mm_read, 0);
        chk("rst_mm_write", mm_if.mm_write, 0);
        chk("rst_mm_a", mm_if.mm_a, 0);
        chk("rst_mm_wd", mm_if.mm_wd, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", req_ready, 1);

        // directed cases
        run_req(3'd0, 32'h0000_0040, 32'h0, 4'h0, rand_line(), 1);
        run_req(3'd2, 32'h0000_0060, 32'h0000_0020, 4'h0, rand_line(), 1);
        run_req(3'd0, 32'h0000_0020, 32'h0, 4'h0, rand_line(), 1);
        run_req(3'd4, 32'h0000_0044, 32'h0, 4'b0010, {224'h0, 32'hAABB_CCDD}, 1);
        run_req(3'd3, 32'h0000_0044, 32'h0, 4'h0, rand_line(), 1);
        chk("byp_byte1", last_rsp[15:8], 8'hCC);
        run_req(3'd4, 32'h0000_0048, 32'h0, 4'b0000, {224'h0, 32'h1234_5678}, 1);
        run_req(3'd0, 32'h0001_0000, 32'h0, 4'h0, rand_line(), 1);
        run_req(3'd2, 32'h0000_0060, 32'h8000_0020, 4'h0, rand_line(), 1);
        run_req(3'd6, 32'h0000_0000, 32'h0, 4'h0, rand_line(), 1);
        run_req(3'd3, 32'h0000_0044, 32'h0, 4'h0, rand_line(), TO + 1);
        run_req(3'd3, 32'h0000_0044, 32'h0, 4'h0, rand_line(), TO);
        run_req(3'd3, 32'h0000_0044, 32'h0, 4'h0, rand_line(), TO - 1);
        run_req(3'd1, 32'h0000_7FE7, 32'h0, 4'h0, rand_line(), 1);

        // spurious mm_valid while idle
        @(posedge clk); #1;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        chk("spur_rsp", rsp_valid, 0);
        chk("spur_ready", req_ready, 1);

        // reset during RD_WAIT with a late mm_valid
        lat_cfg = 5;
        req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h0000_0080;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("rstw_mm_read", mm_if.mm_read, 0);
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            if (rsp_valid) seen = 1;
            @(posedge clk); #1;
        end
        chk("rstw_no_rsp", seen, 0);
        chk("rstw_ready", req_ready, 1);

        // randomized traffic over a handful of aliasing lines
        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 4)      op = 3'(pick);
            else if (pick <= 8) op = 3'($urandom_range(0, 4));
            else                op = 3'($urandom_range(5, 7));
            a  = 32'($urandom_range(0, 7) * 32 + $urandom_range(0, 31));
            wb = 32'($urandom_range(0, 7) * 32 + $urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) a[$urandom_range(IDX + 1, 31)] = 1'b1;
            if ($urandom_range(0, 9) == 0) wb[$urandom_range(IDX + 1, 31)] = 1'b1;
            lat = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TO + 3) : 1;
            run_req(op, a, wb, 4'($urandom), rand_line(), lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
